// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite register file: response codes, the
// out-of-range read pattern and the write/read channel state encodings.
package axi4_lite_pkg;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [1:0]  RESP_SLVERR    = 2'b10;
  localparam logic [31:0] RD_OOR_PATTERN = 32'h0DEC0DE0;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_COMMIT,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

  // Width of a register index; a single-register bank still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_write_channel.sv
// AXI4-Lite write path: independent AW/W capture, one-cycle commit, B response.
// With AXIL_REGFILE_WSTRB_EN defined, only strobed byte lanes are replaced.
module axi4_lite_write_channel
  import axi4_lite_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   i_awaddr,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic                o_bvalid,
  output logic [1:0]          o_bresp,
  input  logic                i_bready,
  input  logic [DATA_W-1:0]   i_old_data,
  output logic                o_wr_en,
  output logic [IDX_W-1:0]    o_wr_idx,
  output logic [DATA_W-1:0]   o_wr_data
);

  localparam int          NB         = DATA_W / 8;
  localparam int          ADDR_LSB   = $clog2(NB);
  localparam int          AIDX_W     = ADDR_W - ADDR_LSB;
  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  wr_state_e          r_state;
  wr_state_e          w_next;
  logic [AIDX_W-1:0]  r_aw_idx;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_aw_held;
  logic               r_w_held;
  logic [1:0]         r_bresp;
  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_in_range;
  logic [NB-1:0]      w_strb;
  logic               w_unused_addr;

  assign o_awready     = (r_state == WR_IDLE) && !r_aw_held;
  assign o_wready      = (r_state == WR_IDLE) && !r_w_held;
  assign o_bvalid      = (r_state == WR_RESP);
  assign o_bresp       = r_bresp;
  assign w_aw_hs       = i_awvalid && o_awready;
  assign w_w_hs        = i_wvalid && o_wready;
  assign w_in_range    = 32'(r_aw_idx) < NUM_REGS_U;
  assign o_wr_idx      = r_aw_idx[IDX_W-1:0];
  assign w_unused_addr = ^i_awaddr[ADDR_LSB-1:0];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WR_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: defaults first, so no path through this block can infer a latch.
  always_comb begin
    w_next  = r_state;
    o_wr_en = 1'b0;
    unique case (r_state)
      WR_IDLE:   if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) w_next = WR_COMMIT;
      WR_COMMIT: begin
        w_next  = WR_RESP;
        o_wr_en = w_in_range;
      end
      WR_RESP:   if (i_bready) w_next = WR_IDLE;
      default:   w_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_idx  <= i_awaddr[ADDR_W-1:ADDR_LSB];
        r_aw_held <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= i_wdata;
        r_w_held <= 1'b1;
      end
      if (r_state == WR_COMMIT) r_bresp <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      if ((r_state == WR_RESP) && i_bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

`ifdef AXIL_REGFILE_WSTRB_EN
  logic [NB-1:0] r_wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_wstrb <= '0;
    else if (w_w_hs) r_wstrb <= i_wstrb;
  end

  assign w_strb = r_wstrb;
`else
  logic w_unused_wstrb;

  assign w_unused_wstrb = ^i_wstrb;
  assign w_strb         = '1;
`endif

  // Lanes without a strobe keep the register's current contents.
  always_comb begin
    o_wr_data = i_old_data;
    for (int b = 0; b < NB; b++) begin
      if (w_strb[b]) o_wr_data[b*8 +: 8] = r_wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS control registers with write pulses.
// Byte-strobe merging is enabled by defining AXIL_REGFILE_WSTRB_EN.
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 8,
  parameter int                        NUM_REGS       = 16,
  parameter logic [AXI_DATA_WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic                               AXI_ACLK,
  input  logic                               AXI_ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                               S_AXI_AWVALID,
  input  logic [2:0]                         S_AXI_AWPROT,
  output logic                               S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic                               S_AXI_BVALID,
  output logic [1:0]                         S_AXI_BRESP,
  input  logic                               S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                               S_AXI_ARVALID,
  input  logic [2:0]                         S_AXI_ARPROT,
  output logic                               S_AXI_ARREADY,
  output logic                               S_AXI_RVALID,
  output logic [1:0]                         S_AXI_RRESP,
  output logic [AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  input  logic                               S_AXI_RREADY,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                wr_pulse
);

  localparam int          ADDR_LSB   = $clog2(AXI_DATA_WIDTH / 8);
  localparam int          AIDX_W     = AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int          REG_IDX_W  = idx_width(NUM_REGS);
  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  logic [AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]       r_wr_pulse;
  logic                      w_wr_en;
  logic [REG_IDX_W-1:0]      w_wr_idx;
  logic [AXI_DATA_WIDTH-1:0] w_wr_data;
  logic [AXI_DATA_WIDTH-1:0] w_wr_old;

  rd_state_e                 r_rd_state;
  rd_state_e                 w_rd_next;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp;
  logic [AIDX_W-1:0]         w_ar_idx;
  logic                      w_ar_in_range;
  logic                      w_ar_hs;
  logic                      w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[ADDR_LSB-1:0]};
  assign w_wr_old = r_regs[w_wr_idx];

  axi4_lite_write_channel #(
    .DATA_W   (AXI_DATA_WIDTH),
    .ADDR_W   (AXI_ADDR_WIDTH),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (REG_IDX_W)
  ) u_write_channel (
    .clk        (AXI_ACLK),
    .rst_n      (AXI_ARESETN),
    .i_awaddr   (S_AXI_AWADDR),
    .i_awvalid  (S_AXI_AWVALID),
    .o_awready  (S_AXI_AWREADY),
    .i_wdata    (S_AXI_WDATA),
    .i_wstrb    (S_AXI_WSTRB),
    .i_wvalid   (S_AXI_WVALID),
    .o_wready   (S_AXI_WREADY),
    .o_bvalid   (S_AXI_BVALID),
    .o_bresp    (S_AXI_BRESP),
    .i_bready   (S_AXI_BREADY),
    .i_old_data (w_wr_old),
    .o_wr_en    (w_wr_en),
    .o_wr_idx   (w_wr_idx),
    .o_wr_data  (w_wr_data)
  );

  // NOTE: these are discrete flops driving fabric, not a RAM, so every word is reset.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_wr_en) begin
        r_regs[w_wr_idx]     <= w_wr_data;
        r_wr_pulse[w_wr_idx] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = r_regs[g];
  end
  assign wr_pulse = r_wr_pulse;

  assign S_AXI_ARREADY = (r_rd_state == RD_IDLE);
  assign S_AXI_RVALID  = (r_rd_state == RD_DATA);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign w_ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_ar_idx      = S_AXI_ARADDR[AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign w_ar_in_range = 32'(w_ar_idx) < NUM_REGS_U;

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) r_rd_state <= RD_IDLE;
    else              r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    unique case (r_rd_state)
      RD_IDLE: if (S_AXI_ARVALID) w_rd_next = RD_DATA;
      RD_DATA: if (S_AXI_RREADY)  w_rd_next = RD_IDLE;
      default: w_rd_next = RD_IDLE;
    endcase
  end

  // Sampled at the AR edge, so a write committing on that same edge is not seen.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      if (w_ar_in_range) begin
        r_rdata <= r_regs[w_ar_idx[REG_IDX_W-1:0]];
        r_rresp <= RESP_OKAY;
      end else begin
        r_rdata <= AXI_DATA_WIDTH'(RD_OOR_PATTERN);
        r_rresp <= RESP_SLVERR;
      end
    end
  end

endmodule

// File: doc/axi4_lite_regfile.md
# axi4_lite_regfile

Parametrised AXI4-Lite slave exposing a bank of NUM_REGS read/write control registers to fabric logic, with full write-channel support (AW/W/B), byte-strobe merging and SLVERR on out-of-range accesses. It sits between the AXI interconnect and user logic. Register contents drive fabric directly, and each register provides a one-cycle write-notification pulse.

## Interface
- AXI_DATA_WIDTH, 32, data width; must be 32 or 64
- AXI_ADDR_WIDTH, 8, byte-address width; must cover NUM_REGS*(AXI_DATA_WIDTH/8) bytes
- NUM_REGS, 16, number of registers, 1..256
- RESET_VALUE, 0, reset contents of every register
- AXI_ACLK  in  1  sole clock
- AXI_ARESETN  in  1  reset, asynchronous, active-low
- S_AXI_AWADDR/AWVALID/AWPROT, S_AXI_WDATA/WSTRB/WVALID, S_AXI_BREADY, S_AXI_ARADDR/ARVALID/ARPROT, S_AXI_RREADY  in  standard AXI4-Lite widths
- S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP[1:0], S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP[1:0], S_AXI_RDATA  out  standard AXI4-Lite widths
- reg_out  out  NUM_REGS*AXI_DATA_WIDTH  flattened register contents; register i occupies [i*W +: W]
- wr_pulse  out  NUM_REGS  bit i high for one cycle after register i is written

## Operation
- Register index = addr[AXI_ADDR_WIDTH-1:log2(W/8)]. Low byte-offset bits are ignored. An index >= NUM_REGS is out of range.
- AWPROT/ARPROT are ignored.
- Write FSM states:
  - IDLE: AWREADY=WREADY=1. AW and W are captured independently, in either order or simultaneously. Each ready deasserts after its own handshake.
  - COMMIT, entered once both are held: a single cycle. An in-range write updates the register and sets wr_pulse[i]. An out-of-range write leaves registers unchanged and sets BRESP=SLVERR, otherwise OKAY. BVALID rises.
  - RESP: hold BVALID/BRESP until BREADY. On the handshake, go to IDLE with AWREADY=WREADY=1.
- Read FSM states:
  - IDLE: ARREADY=1. On ARVALID, capture the address and drop ARREADY.
  - DATA: RVALID=1. RDATA = register value, or 32'h0DEC0DE0 (zero-extended to W) with RRESP=SLVERR when out of range. Hold until RREADY, then return to IDLE with ARREADY=1.
- Read and write FSMs run concurrently.
- A read of register i captures the contents as of its AR handshake edge. A write committing on that same edge is not visible to that read.

## Timing
- Reset values:
  - AWREADY=WREADY=ARREADY=1 (held 1 while in reset).
  - BVALID=RVALID=0, BRESP=RRESP=OKAY, RDATA=0.
  - reg_out=RESET_VALUE for every register; wr_pulse=0.
- Write latency: the later AW/W handshake happens at edge E. The register updates and BVALID rises at E+1. wr_pulse is high during the cycle E+1..E+2.
- Read latency: AR handshake at edge E, RVALID and RDATA valid from E+1.
- BVALID/RVALID never drop without the matching READY. Data and response are stable while VALID is high.
- BREADY or RREADY held high in advance: the handshake completes on the first VALID cycle, and READY re-asserts on the following cycle.
- Back-to-back throughput: one write per 3 cycles, one read per 2 cycles.
- Reset asserted mid-transaction: all outputs go to reset values immediately and the transaction is discarded. No B/R response is ever issued for it.

## Configuration
- AXIL_REGFILE_WSTRB_EN defined: byte lane b is written only where WSTRB[b]=1; other lanes keep their old value. WSTRB=0 to an in-range register still returns OKAY and pulses wr_pulse.
- Not defined: WSTRB is ignored and every write replaces the full word.

## Structure
- Shared package axi4_lite_pkg holds:
  - response constants OKAY=2'b00, SLVERR=2'b10;
  - the out-of-range read pattern 32'h0DEC0DE0;
  - write-FSM and read-FSM state enums.
- Natural sub-module: axi4_lite_write_channel. It covers AW/W capture, the B FSM and strobe merge, and outputs a write-enable, index and merged data to the register bank.
- The read path and register bank stay in the top module.

## Test plan
- Reset, then read register 0 → RVALID one cycle after AR, RDATA=RESET_VALUE, RRESP=OKAY.
- Write 0xA5A5_1234 to addr 0x08 with AW one cycle before W, then read 0x08 → BRESP=OKAY, wr_pulse[2] single cycle, readback 0xA5A5_1234, other reg_out slices unchanged.
- With AXIL_REGFILE_WSTRB_EN, write 0xFFFF_FFFF with WSTRB=4'b0101 to register 1 (initially 0) → readback 0x00FF_00FF. Without the macro → 0xFFFF_FFFF.
- Write and read address 4*NUM_REGS → BRESP=SLVERR with no register or wr_pulse change; RDATA=0x0DEC0DE0, RRESP=SLVERR.
- Hold BREADY/RREADY low 5 cycles → BVALID/RVALID and their data stay stable, AWREADY/WREADY/ARREADY stay 0; handshake completes when READY rises.
- Assert AXI_ARESETN=0 between the AW handshake and BVALID → no BVALID after release, register unchanged, all readies 1.
